lsu_dmem_ctrl: RTL and testbench

Load/store controller between the single-cycle core's memory stage and the word-wide data memory. It accepts byte-addressed load/store requests of byte, halfword or word size. It drives the memory's MemRead/MemWrite/address/write-data port and returns aligned, extended load data. Sub-word stores use read-modify-write, because the data memory only writes full 32-bit words.

---
 rtl/lsu_dmem_if.sv | 39 +++
 rtl/lsu_dmem_ctrl.sv | 178 +++++++++++++++++
 tb/tb_lsu_dmem_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/lsu_dmem_if.sv
// Request/response and data-memory port bundle for the load/store controller.
// Latency: none (signal bundle only).
// Backpressure: req_ready gates request acceptance; the memory side has none.
interface lsu_dmem_if #(
    parameter int DM_AW = 7
);
    // core memory-stage request
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    // completion
    logic              rsp_valid;
    logic              rsp_err;
    logic [31:0]       rsp_rdata;
    // word-wide data memory
    logic              mem_read;
    logic              mem_write;
    logic [DM_AW-1:0]  mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    // controller side
    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_err, rsp_rdata,
               mem_read, mem_write, mem_addr, mem_wdata
    );

    // core + memory side
    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata,
               mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_dmem_ctrl.sv
// Load/store controller: byte/half/word requests onto a word-only data memory (RMW for sub-word stores).
// Latency: error 1, load 2, word store 2, sub-word store 3 cycles from accept to rsp_valid.
// Backpressure: req_ready only in IDLE; one request in flight, no queuing. Sub-word support: `LSU_SUBWORD_EN.
module lsu_dmem_ctrl #(
    parameter int DM_AW    = 7,
    parameter int DM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    lsu_dmem_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_e;

    state_e            state_q, state_d;
    logic              we_q;
    logic [DM_AW-1:0]  mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic              rsp_err_q;
    logic [31:0]       rsp_rdata_q;

    logic              accept;
    logic              req_err;
    logic [31:0]       load_ext;   // aligned/extended load result from mem_rdata
    logic [31:0]       store_mrg;  // read word with the store lane replaced

`ifdef LSU_SUBWORD_EN
    logic [1:0]        size_q;
    logic              signed_q;
    logic [1:0]        lane_q;
    logic [15:0]       wdata_q;
`endif

    assign accept = bus.req_valid && (state_q == IDLE);

    // request legality: illegal size, then misalignment, then out of range
    always_comb begin
        req_err = 1'b0;
`ifdef LSU_SUBWORD_EN
        if (bus.req_size == 2'b11)
            req_err = 1'b1;
        else if ((bus.req_size == 2'b01) && bus.req_addr[0])
            req_err = 1'b1;
        else if ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00))
            req_err = 1'b1;
`else
        if (bus.req_size != 2'b10)
            req_err = 1'b1;
        else if (bus.req_addr[1:0] != 2'b00)
            req_err = 1'b1;
`endif
        else if (bus.req_addr >= 32'(4 * DM_WORDS))
            req_err = 1'b1;
    end

`ifdef LSU_SUBWORD_EN
    // lane extraction with zero/sign extension, and lane merge for RMW stores
    always_comb begin
        logic [7:0]  b;
        logic [15:0] h;
        b         = bus.mem_rdata[{lane_q, 3'b000} +: 8];
        h         = bus.mem_rdata[{lane_q[1], 4'b0000} +: 16];
        load_ext  = bus.mem_rdata;
        store_mrg = bus.mem_rdata;
        case (size_q)
            2'b00: begin
                load_ext = signed_q ? {{24{b[7]}}, b} : {24'h0, b};
                store_mrg[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
            end
            2'b01: begin
                load_ext = signed_q ? {{16{h[15]}}, h} : {16'h0, h};
                store_mrg[{lane_q[1], 4'b0000} +: 16] = wdata_q;
            end
            default: ;
        endcase
    end
`else
    logic unused_signed;
    assign unused_signed = bus.req_signed;

    // word-only build: loads pass straight through, no merge path
    always_comb begin
        load_ext  = bus.mem_rdata;
        store_mrg = bus.mem_rdata;
    end
`endif

    // state register; async reset drops mem_write at once so no write commits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // next state and state-decoded outputs
    always_comb begin
        state_d       = state_q;
        bus.req_ready = 1'b0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (accept) begin
                    if (req_err)
                        state_d = RSP;
`ifdef LSU_SUBWORD_EN
                    else if (bus.req_we && (bus.req_size == 2'b10))
                        state_d = WR;
`else
                    else if (bus.req_we)
                        state_d = WR;
`endif
                    else
                        state_d = RD;
                end
            end
            RD: begin
                bus.mem_read = 1'b1;
                state_d      = we_q ? WR : RSP;
            end
            WR: begin
                bus.mem_write = 1'b1;
                state_d       = RSP;
            end
            RSP: begin
                bus.rsp_valid = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // request capture, memory address/data and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef LSU_SUBWORD_EN
            size_q      <= 2'b00;
            signed_q    <= 1'b0;
            lane_q      <= 2'b00;
            wdata_q     <= '0;
`endif
        end else begin
            if (accept) begin
                we_q       <= bus.req_we;
                mem_addr_q <= bus.req_addr[DM_AW+1:2];
                rsp_err_q  <= req_err;
`ifdef LSU_SUBWORD_EN
                size_q     <= bus.req_size;
                signed_q   <= bus.req_signed;
                lane_q     <= bus.req_addr[1:0];
                wdata_q    <= bus.req_wdata[15:0];
`endif
                // word stores drive the data straight away; RMW overwrites it in RD
                if (!req_err && bus.req_we)
                    mem_wdata_q <= bus.req_wdata;
                if (req_err)
                    rsp_rdata_q <= '0;
            end
            if (state_q == RD) begin
                if (we_q) mem_wdata_q <= store_mrg;
                else      rsp_rdata_q <= load_ext;
            end
            if (state_q == WR)
                rsp_rdata_q <= '0;
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
module tb_lsu_dmem_ctrl;
    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    lsu_dmem_if #(.DM_AW(7)) bus ();

    lsu_dmem_ctrl #(.DM_AW(7), .DM_WORDS(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // data memory model: combinational read, write at the rising edge
    logic [31:0] dmem [0:127];
    assign bus.mem_rdata = bus.mem_read ? dmem[bus.mem_addr] : 32'h0;
    always @(posedge clk) if (bus.mem_write) dmem[bus.mem_addr] <= bus.mem_wdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // observations from the most recent transaction
    int          lat, n_rd, n_wr, n_both;
    logic [31:0] r_err, r_data, w_addr, w_data;

    task automatic xact(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 1; n_rd = 0; n_wr = 0; n_both = 0; w_addr = '1; w_data = '1;
        forever begin
            if (bus.mem_read) n_rd++;
            if (bus.mem_write) begin
                n_wr++;
                w_addr = 32'(bus.mem_addr);
                w_data = bus.mem_wdata;
            end
            if (bus.mem_read && bus.mem_write) n_both++;
            if (bus.rsp_valid || lat >= 8) break;
            @(posedge clk); #1;
            lat++;
        end
        chk("rsp_seen", 32'(bus.rsp_valid), 32'd1);
        r_err  = 32'(bus.rsp_err);
        r_data = bus.rsp_rdata;
        @(posedge clk); #1;
        chk("rsp_pulse", 32'(bus.rsp_valid), 32'd0);
        chk("rd_held", bus.rsp_rdata, r_data);
    endtask

    task automatic expect_rsp(input string tag, input int e_lat, input logic e_err,
                              input logic [31:0] e_data, input int e_rd, input int e_wr);
        chk({tag, ".lat"},  32'(lat),  32'(e_lat));
        chk({tag, ".err"},  r_err,     32'(e_err));
        chk({tag, ".data"}, r_data,    e_data);
        chk({tag, ".nrd"},  32'(n_rd), 32'(e_rd));
        chk({tag, ".nwr"},  32'(n_wr), 32'(e_wr));
        chk({tag, ".both"}, 32'(n_both), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) dmem[i] = 32'h0;
        dmem[8] = 32'h1122_3344;
        bus.req_valid = 0; bus.req_we = 0; bus.req_size = 0;
        bus.req_signed = 0; bus.req_addr = 0; bus.req_wdata = 0;
        rst = 1'b1;
        #12;
        chk("rst.ready", 32'(bus.req_ready), 32'd1);
        chk("rst.rspv",  32'(bus.rsp_valid), 32'd0);
        chk("rst.err",   32'(bus.rsp_err),   32'd0);
        chk("rst.rdata", bus.rsp_rdata,      32'h0);
        chk("rst.memrw", {30'h0, bus.mem_read, bus.mem_write}, 32'h0);
        chk("rst.maddr", 32'(bus.mem_addr),  32'h0);
        chk("rst.mwdat", bus.mem_wdata,      32'h0);
        @(negedge clk); rst = 1'b0;

        // word store then load
        xact(1, 2'b10, 0, 32'h10, 32'h8081_82F3);
        expect_rsp("sw", 2, 0, 32'h0, 0, 1);
        chk("sw.maddr", w_addr, 32'd4);
        chk("sw.mwdat", w_data, 32'h8081_82F3);
        chk("sw.mem",   dmem[4], 32'h8081_82F3);
        xact(0, 2'b10, 0, 32'h10, 32'h0);
        expect_rsp("lw", 2, 0, 32'h8081_82F3, 1, 0);

`ifdef LSU_SUBWORD_EN
        xact(0, 2'b00, 1, 32'h10, 32'h0);
        expect_rsp("lb", 2, 0, 32'hFFFF_FFF3, 1, 0);
        xact(0, 2'b00, 0, 32'h13, 32'h0);
        expect_rsp("lbu", 2, 0, 32'h0000_0080, 1, 0);
        xact(0, 2'b01, 1, 32'h12, 32'h0);
        expect_rsp("lh", 2, 0, 32'hFFFF_8081, 1, 0);
        xact(0, 2'b01, 0, 32'h10, 32'h0);
        expect_rsp("lhu", 2, 0, 32'h0000_82F3, 1, 0);
        xact(1, 2'b00, 0, 32'h11, 32'h0000_00AA);
        expect_rsp("sb", 3, 0, 32'h0, 1, 1);
        chk("sb.maddr", w_addr, 32'd4);
        chk("sb.mwdat", w_data, 32'h8081_AAF3);
        xact(0, 2'b10, 0, 32'h10, 32'h0);
        expect_rsp("lw2", 2, 0, 32'h8081_AAF3, 1, 0);
        xact(0, 2'b01, 0, 32'h01, 32'h0);
        expect_rsp("e.lh1", 1, 1, 32'h0, 0, 0);
`else
        xact(0, 2'b00, 1, 32'h10, 32'h0);
        expect_rsp("e.lb", 1, 1, 32'h0, 0, 0);
        xact(1, 2'b01, 0, 32'h10, 32'h0000_1234);
        expect_rsp("e.sh", 1, 1, 32'h0, 0, 0);
        chk("e.sh.mem", dmem[4], 32'h8081_82F3);
`endif

        // error cases
        xact(0, 2'b10, 0, 32'h06, 32'h0);
        expect_rsp("e.lw6", 1, 1, 32'h0, 0, 0);
        xact(0, 2'b11, 0, 32'h10, 32'h0);
        expect_rsp("e.sz3", 1, 1, 32'h0, 0, 0);
        xact(0, 2'b10, 0, 32'h100, 32'h0);
        expect_rsp("e.range", 1, 1, 32'h0, 0, 0);
        xact(1, 2'b10, 0, 32'hFC, 32'h5555_AAAA);
        expect_rsp("sw.top", 2, 0, 32'h0, 0, 1);
        chk("sw.top.mem", dmem[63], 32'h5555_AAAA);

        // reset while a word store sits in WR
        @(negedge clk);
        bus.req_valid = 1; bus.req_we = 1; bus.req_size = 2'b10;
        bus.req_addr = 32'h20; bus.req_wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bus.req_valid = 0;
        chk("rstwr.inwr", 32'(bus.mem_write), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rstwr.mw",    32'(bus.mem_write), 32'd0);
        chk("rstwr.ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("rstwr.norsp", 32'(bus.rsp_valid), 32'd0);
        end
        chk("rstwr.mem", dmem[8], 32'h1122_3344);
        xact(0, 2'b10, 0, 32'h20, 32'h0);
        expect_rsp("rstwr.lw", 2, 0, 32'h1122_3344, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
